display_scan_sequencer: RTL and testbench
=========================================

Name: display_scan_sequencer

Overview:
- Time-multiplexes two 4-bit hex digits onto a shared seven-segment bus.
- Generates the digit-select `enable` that drives the downstream two_bit_demux. The demux decodes `enable` into the per-display `control` drive.
- Inserts a blanking gap at every digit switch so the outgoing digit does not ghost onto the incoming display.
- Double-buffers new digit values so both displays always change together at a frame boundary.

Parameters:
- SHOW_CYCLES, 24000: clk cycles each digit is lit per frame. Must be ≥1.
- BLANK_CYCLES, 240: clk cycles of blanking after each SHOW phase. 0 means no gap.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- digit0, input, 4: hex value for display 0.
- digit1, input, 4: hex value for display 1.
- update, input, 1: single-cycle request to load digit0/digit1 as the next pair to display.
- enable, output, 1: digit select into two_bit_demux. 0 selects display 0, 1 selects display 1.
- blank, output, 1: high means the segment and display drivers must be off.
- digit_out, output, 4: hex value for the segment decoder.
- frame_done, output, 1: one-cycle pulse on the last cycle of each frame.

Behaviour:
- Single clock domain. All state changes on the rising edge of clk.
- All outputs decode registered state and shadow registers only. There is no combinational path from inputs to outputs.
- Reset (synchronous, active-high, takes priority over everything):
  - State = SHOW0, phase counter = 0.
  - shadow0 = shadow1 = 0, pending_valid = 0.
  - Outputs: enable=0, blank=0, digit_out=0, frame_done=0.
  - Reset asserted in any state, including mid-gap, produces these values on the next edge.
- State machine, in order SHOW0 → GAP0 → SHOW1 → GAP1 → SHOW0:
  - SHOW0: enable=0, blank=0, digit_out=shadow0. Lasts SHOW_CYCLES cycles.
  - GAP0: enable=1, blank=1, digit_out=shadow1. Lasts BLANK_CYCLES cycles. Select and data settle before the display turns on.
  - SHOW1: enable=1, blank=0, digit_out=shadow1. Lasts SHOW_CYCLES cycles.
  - GAP1: enable=0, blank=1, digit_out=shadow0. Lasts BLANK_CYCLES cycles.
  - If BLANK_CYCLES=0, the GAP states are skipped (SHOW0↔SHOW1 directly) and blank stays 0 permanently.
- Phase counter:
  - Width is $clog2(max(SHOW_CYCLES, BLANK_CYCLES, 2)).
  - Counts 0..N-1 within the current state and resets to 0 on every state transition.
- Frame:
  - Frame length is 2·(SHOW_CYCLES+BLANK_CYCLES) cycles.
  - frame_done=1 for exactly one cycle: the last cycle of GAP1, or the last cycle of SHOW1 when BLANK_CYCLES=0.
- Double buffering:
  - Any cycle with update=1 captures digit0/digit1 into pending registers and sets pending_valid=1.
  - A later update overwrites pending (last wins).
- Frame boundary (the edge ending the frame_done cycle):
  - If update=1 on that cycle: shadow0/shadow1 load the digit0/digit1 inputs directly. pending_valid clears.
  - Else if pending_valid=1: shadow0/shadow1 load the pending registers. pending_valid clears.
  - Otherwise the shadows hold.
- Shadows never change mid-frame.
- update during reset is ignored.

Test Plan (instance SHOW_CYCLES=4, BLANK_CYCLES=2, frame = 12 cycles, unless noted):
- Reset: hold reset for 3 cycles, then release.
  - While in reset: enable=0, blank=0, digit_out=0, frame_done=0.
  - After release: SHOW0 lasts exactly 4 cycles, and the first frame_done appears on cycle 12 after release.
- Steady scan: pulse update with digit0=3, digit1=A during frame 1.
  - Frame 1 shows digit_out=0 on both digits.
  - Frame 2 onward, repeating every 12 cycles:
    - 4 cycles of {enable=0, blank=0, digit_out=3}
    - 2 cycles of {1, 1, A}
    - 4 cycles of {1, 0, A}
    - 2 cycles of {0, 1, 3}
  - frame_done pulses once per 12 cycles.
  - A bench instantiating two_bit_demux on `enable` sees its `control` alternate in step with `enable`.
- Mid-frame update: with 3/A displayed, pulse update with 5/6 in the second SHOW1 cycle.
  - Remainder of the frame still shows 3/A.
  - The next frame shows 5 then 6.
- Coincident/last-wins:
  - Pulse update 7/8 mid-frame, then update 9/B on the frame_done cycle → next frame shows 9/B.
  - Separately, updates 1/2 then 4/4 in the same frame → next frame shows 4/4.
- No-gap instance: SHOW_CYCLES=3, BLANK_CYCLES=0.
  - blank is never 1.
  - enable toggles every 3 cycles.
  - frame_done pulses every 6 cycles.
- Reset mid-operation: assert reset in the first GAP1 cycle.
  - Next cycle: enable=0, blank=0, digit_out=0.
  - Pending cleared: no old value appears after reset release.

Source files
------------

// File: rtl/display_scan_sequencer_if.sv
// Digit load request and scan outputs shared between the digit source (master)
// and the two-digit scan sequencer (slave).
interface display_scan_sequencer_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       update;
    logic       enable;
    logic       blank;
    logic [3:0] digit_out;
    logic       frame_done;

    modport master (
        output digit0, digit1, update,
        input  enable, blank, digit_out, frame_done
    );

    modport slave (
        input  digit0, digit1, update,
        output enable, blank, digit_out, frame_done
    );
endinterface

// File: rtl/display_scan_sequencer.sv
// Two-digit seven-segment scan sequencer: alternates digits with blanking gaps and
// double-buffers digit updates so both digits change together at a frame boundary.
module display_scan_sequencer #(
    parameter int SHOW_CYCLES  = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                          clk,
    input  logic                          reset,
    display_scan_sequencer_if.slave       bus
);

    localparam int MAX_A = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int MAX_C = (MAX_A > 2) ? MAX_A : 2;
    localparam int CW    = $clog2(MAX_C);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam bit            HAS_GAP    = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s, succ_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          last_s;
    logic [3:0]    shadow0_r, shadow1_r, shadow0_nxt_s, shadow1_nxt_s;
    logic [3:0]    pend0_r, pend1_r, pend0_nxt_s, pend1_nxt_s;
    logic          pend_valid_r, pend_valid_nxt_s;
    logic          enable_r, blank_r, frame_done_r;
    logic [3:0]    digit_out_r;
    logic          enable_nxt_s, blank_nxt_s, frame_done_nxt_s;
    logic [3:0]    digit_out_nxt_s;

    // Phase sequencing: detect the last cycle of the current phase and pick its successor.
    always_comb begin
        last_s = 1'b1;
        succ_s = SHOW0;
        case (state_r)
            SHOW0: begin
                last_s = (cnt_r == SHOW_LAST);
                succ_s = HAS_GAP ? GAP0 : SHOW1;
            end
            GAP0: begin
                last_s = (cnt_r == BLANK_LAST);
                succ_s = SHOW1;
            end
            SHOW1: begin
                last_s = (cnt_r == SHOW_LAST);
                succ_s = HAS_GAP ? GAP1 : SHOW0;
            end
            GAP1: begin
                last_s = (cnt_r == BLANK_LAST);
                succ_s = SHOW0;
            end
            default: begin
                last_s = 1'b1;
                succ_s = SHOW0;
            end
        endcase
        if (last_s) begin
            state_nxt_s = succ_s;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r + CW'(1);
        end
    end

    // Double buffer: frame_done_r marks the frame's last cycle, so its closing edge is the swap point.
    always_comb begin
        shadow0_nxt_s    = shadow0_r;
        shadow1_nxt_s    = shadow1_r;
        pend0_nxt_s      = pend0_r;
        pend1_nxt_s      = pend1_r;
        pend_valid_nxt_s = pend_valid_r;
        if (frame_done_r) begin
            pend_valid_nxt_s = 1'b0;
            if (bus.update) begin
                shadow0_nxt_s = bus.digit0;
                shadow1_nxt_s = bus.digit1;
            end else if (pend_valid_r) begin
                shadow0_nxt_s = pend0_r;
                shadow1_nxt_s = pend1_r;
            end else begin
                shadow0_nxt_s = shadow0_r;
                shadow1_nxt_s = shadow1_r;
            end
        end else if (bus.update) begin
            pend0_nxt_s      = bus.digit0;
            pend1_nxt_s      = bus.digit1;
            pend_valid_nxt_s = 1'b1;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // Output decode of the upcoming state so the outputs can be registered without lag.
    always_comb begin
        enable_nxt_s    = 1'b0;
        blank_nxt_s     = 1'b0;
        digit_out_nxt_s = shadow0_nxt_s;
        case (state_nxt_s)
            SHOW0: begin enable_nxt_s = 1'b0; blank_nxt_s = 1'b0; digit_out_nxt_s = shadow0_nxt_s; end
            GAP0:  begin enable_nxt_s = 1'b1; blank_nxt_s = 1'b1; digit_out_nxt_s = shadow1_nxt_s; end
            SHOW1: begin enable_nxt_s = 1'b1; blank_nxt_s = 1'b0; digit_out_nxt_s = shadow1_nxt_s; end
            GAP1:  begin enable_nxt_s = 1'b0; blank_nxt_s = 1'b1; digit_out_nxt_s = shadow0_nxt_s; end
            default: begin enable_nxt_s = 1'b0; blank_nxt_s = 1'b0; digit_out_nxt_s = shadow0_nxt_s; end
        endcase
        if (HAS_GAP) begin
            frame_done_nxt_s = (state_nxt_s == GAP1) && (cnt_nxt_s == BLANK_LAST);
        end else begin
            frame_done_nxt_s = (state_nxt_s == SHOW1) && (cnt_nxt_s == SHOW_LAST);
        end
    end

    // State, buffers and registered outputs; reset has priority over every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SHOW0;
            cnt_r        <= {CW{1'b0}};
            shadow0_r    <= 4'd0;
            shadow1_r    <= 4'd0;
            pend0_r      <= 4'd0;
            pend1_r      <= 4'd0;
            pend_valid_r <= 1'b0;
            enable_r     <= 1'b0;
            blank_r      <= 1'b0;
            digit_out_r  <= 4'd0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            shadow0_r    <= shadow0_nxt_s;
            shadow1_r    <= shadow1_nxt_s;
            pend0_r      <= pend0_nxt_s;
            pend1_r      <= pend1_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            enable_r     <= enable_nxt_s;
            blank_r      <= blank_nxt_s;
            digit_out_r  <= digit_out_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    assign bus.enable     = enable_r;
    assign bus.blank      = blank_r;
    assign bus.digit_out  = digit_out_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench: phase table for a 4/2 instance plus a hand sequence for a 3/0 instance.
module tb_display_scan_sequencer;

    logic clk;
    logic reset;
    logic reset_ng;
    int   checks;
    int   errors;

    display_scan_sequencer_if bus_g ();
    display_scan_sequencer_if bus_n ();

    display_scan_sequencer #(.SHOW_CYCLES(4), .BLANK_CYCLES(2)) u_gap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_g)
    );

    display_scan_sequencer #(.SHOW_CYCLES(3), .BLANK_CYCLES(0)) u_nogap (
        .clk   (clk),
        .reset (reset_ng),
        .bus   (bus_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record covers n cycles of a steady phase; update pulses only in its first cycle.
    typedef struct {
        logic       rst;
        logic       upd;
        logic [3:0] d0;
        logic [3:0] d1;
        int         n;
        logic       en;
        logic       bl;
        logic [3:0] dig;
        logic       fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic upd, input logic [3:0] d0,
                                input logic [3:0] d1, input int n, input logic en,
                                input logic bl, input logic [3:0] dig, input logic fd);
        vec_t v;
        v.rst = rst; v.upd = upd; v.d0 = d0; v.d1 = d1; v.n = n;
        v.en = en; v.bl = bl; v.dig = dig; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        reset_ng = 1'b1;
        bus_g.update = 1'b0; bus_g.digit0 = 4'd0; bus_g.digit1 = 4'd0;
        bus_n.update = 1'b0; bus_n.digit0 = 4'd0; bus_n.digit1 = 4'd0;

        // reset for 3 cycles, with an update that must be ignored
        tbl.push_back(mk(1'b1, 1'b1, 4'hC, 4'hC, 3, 1'b0, 1'b0, 4'h0, 1'b0));
        // frame 1: zeros, update 3/A
        tbl.push_back(mk(1'b0, 1'b1, 4'h3, 4'hA, 4, 1'b0, 1'b0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 2, 1'b1, 1'b1, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 4, 1'b1, 1'b0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 2, 1'b0, 1'b1, 4'h0, 1'b1));
        // frame 2: 3/A
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 4, 1'b0, 1'b0, 4'h3, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 2, 1'b1, 1'b1, 4'hA, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 4, 1'b1, 1'b0, 4'hA, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 2, 1'b0, 1'b1, 4'h3, 1'b1));
        // frame 3: 3/A, update 5/6 in second SHOW1 cycle
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 4, 1'b0, 1'b0, 4'h3, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 2, 1'b1, 1'b1, 4'hA, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 4'hA, 1, 1'b1, 1'b0, 4'hA, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h5, 4'h6, 3, 1'b1, 1'b0, 4'hA, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h5, 4'h6, 2, 1'b0, 1'b1, 4'h3, 1'b1));
        // frame 4: 5/6, update 7/8 mid-frame then 9/B on the frame_done cycle
        tbl.push_back(mk(1'b0, 1'b0, 4'h5, 4'h6, 1, 1'b0, 1'b0, 4'h5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h7, 4'h8, 3, 1'b0, 1'b0, 4'h5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h7, 4'h8, 2, 1'b1, 1'b1, 4'h6, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h7, 4'h8, 4, 1'b1, 1'b0, 4'h6, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h7, 4'h8, 1, 1'b0, 1'b1, 4'h5, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h9, 4'hB, 1, 1'b0, 1'b1, 4'h5, 1'b1));
        // frame 5: 9/B, updates 1/2 then 4/4 (last wins)
        tbl.push_back(mk(1'b0, 1'b0, 4'h9, 4'hB, 1, 1'b0, 1'b0, 4'h9, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h1, 4'h2, 3, 1'b0, 1'b0, 4'h9, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h1, 4'h2, 2, 1'b1, 1'b1, 4'hB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h4, 4'h4, 1, 1'b1, 1'b0, 4'hB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h4, 4'h4, 3, 1'b1, 1'b0, 4'hB, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h4, 4'h4, 2, 1'b0, 1'b1, 4'h9, 1'b1));
        // frame 6: 4/4, pending 7/7, reset (with update 9/9) in first GAP1 cycle
        tbl.push_back(mk(1'b0, 1'b0, 4'h4, 4'h4, 4, 1'b0, 1'b0, 4'h4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h4, 4'h4, 2, 1'b1, 1'b1, 4'h4, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 4'h7, 4'h7, 4, 1'b1, 1'b0, 4'h4, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'h9, 4'h9, 1, 1'b0, 1'b1, 4'h4, 1'b0));
        // after reset: zeros through two frame boundaries, nothing stale appears
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 4, 1'b0, 1'b0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 2, 1'b1, 1'b1, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 4, 1'b1, 1'b0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 2, 1'b0, 1'b1, 4'h0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 4, 1'b0, 1'b0, 4'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h0, 4'h0, 2, 1'b1, 1'b1, 4'h0, 1'b0));

        for (int e = 0; e < tbl.size(); e++) begin
            for (int i = 0; i < tbl[e].n; i++) begin
                @(negedge clk);
                chk($sformatf("enable[%0d.%0d]", e, i), int'(bus_g.enable), int'(tbl[e].en));
                chk($sformatf("blank[%0d.%0d]", e, i), int'(bus_g.blank), int'(tbl[e].bl));
                chk($sformatf("digit_out[%0d.%0d]", e, i), int'(bus_g.digit_out), int'(tbl[e].dig));
                chk($sformatf("frame_done[%0d.%0d]", e, i), int'(bus_g.frame_done),
                    int'(tbl[e].fd && (i == tbl[e].n - 1)));
                reset        = tbl[e].rst;
                bus_g.update = tbl[e].upd && (i == 0);
                bus_g.digit0 = tbl[e].d0;
                bus_g.digit1 = tbl[e].d1;
            end
        end
        bus_g.update = 1'b0;

        // no-gap instance: release reset with update 5/C loaded in cycle 0
        @(negedge clk);
        chk("ng_reset_enable", int'(bus_n.enable), 0);
        chk("ng_reset_digit", int'(bus_n.digit_out), 0);
        reset_ng     = 1'b0;
        bus_n.update = 1'b1;
        bus_n.digit0 = 4'h5;
        bus_n.digit1 = 4'hC;
        for (int k = 0; k < 24; k++) begin
            int exp_en;
            int exp_dig;
            if (k > 0) begin
                @(negedge clk);
                bus_n.update = 1'b0;
            end
            exp_en  = (k / 3) % 2;
            exp_dig = (k < 6) ? 0 : ((exp_en == 0) ? 5 : 12);
            chk($sformatf("ng_enable[%0d]", k), int'(bus_n.enable), exp_en);
            chk($sformatf("ng_blank[%0d]", k), int'(bus_n.blank), 0);
            chk($sformatf("ng_frame_done[%0d]", k), int'(bus_n.frame_done), int'((k % 6) == 5));
            chk($sformatf("ng_digit_out[%0d]", k), int'(bus_n.digit_out), exp_dig);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
